serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor. Computes A − B one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow.
- It is the inverse-direction counterpart of the team's 1-bit gate-level full adder and the companion to the ripple adder datapath.
- It is area-minimal and is used by the ALU slow path and by lab multi-cycle datapaths.
- Valid/ready handshake on both the input and the output side.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_full_subtractor.sv | 39 +++
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : State encoding and default width for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : 1-bit full subtractor built from 2-input NAND gates only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_n_ab;
    logic w_t_a;
    logic w_t_b;
    logic w_x;
    logic w_n_xb;
    logic w_t_x;
    logic w_t_bin;

    // Each NAND-XOR stage also yields the ~a&b style borrow terms for free.
    assign w_n_ab  = ~(a & b);
    assign w_t_a   = ~(a & w_n_ab);
    assign w_t_b   = ~(b & w_n_ab);
    assign w_x     = ~(w_t_a & w_t_b);

    assign w_n_xb  = ~(w_x & bin);
    assign w_t_x   = ~(w_x & w_n_xb);
    assign w_t_bin = ~(bin & w_n_xb);
    assign d       = ~(w_t_x & w_t_bin);

    assign bout    = ~(w_t_b & w_t_bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial A - B, LSB first, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int             CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_count;
    logic             r_borrow;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             w_accept;
    logic             w_d;
    logic             w_bout;

    full_subtractor u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next_state = in_valid ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next_state = (r_count == C_LAST) ? ST_DONE : ST_RUN;
            ST_DONE: w_next_state = out_ready ? ST_IDLE : ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    assign w_accept = in_valid & in_ready;

    // Datapath holds its last values outside RUN so results stay visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_diff   <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_diff   <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_sign_a <= A[WIDTH-1];
            r_sign_b <= B[WIDTH-1];
        end else if (r_state == ST_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_diff   <= {w_d, r_diff[WIDTH-1:1]};
            r_count  <= r_count + 1'b1;
            r_borrow <= w_bout;
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = (r_sign_a ^ r_sign_b) & (r_diff[WIDTH-1] ^ r_sign_a);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench: 8-bit vector table plus 32-bit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int N_RAND = 1000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       of;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        of;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, iv8, ir8, ov8, or8, bo8, of8;
    logic [7:0] a8, b8, d8;
    logic        rst32, iv32, ir32, ov32, or32, bo32, of32;
    logic [31:0] a32, b32, d32;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[9];
    exp_t sb_q[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .out_valid(ov8), .out_ready(or8),
        .diff(d8), .borrow_out(bo8), .overflow(of8)
    );

    serial_subtractor #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(rst32), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .out_valid(ov32), .out_ready(or32),
        .diff(d32), .borrow_out(bo32), .overflow(of32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Starts #1 after an edge with the 8-bit DUT idle; leaves it in DONE unless retire=1.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                        input logic eb, input logic eo, input bit retire);
        int lat;
        chk("in_ready_before_accept", {63'd0, ir8}, 64'd1);
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8  = ~a;
        b8  = 8'($urandom);
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            a8 = 8'($urandom);
            lat++;
        end
        chk("latency8", 64'(lat), 64'd8);
        chk("diff8", {56'd0, d8}, {56'd0, ed});
        chk("borrow8", {63'd0, bo8}, {63'd0, eb});
        chk("overflow8", {63'd0, of8}, {63'd0, eo});
        if (retire) begin
            or8 = 1'b1;
            @(posedge clk); #1;
            or8 = 1'b0;
            chk("retire_out_valid8", {63'd0, ov8}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        rst32 = 1'b1; iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

        #3;
        chk("rst_in_ready", {63'd0, ir8}, 64'd1);
        chk("rst_out_valid", {63'd0, ov8}, 64'd0);
        chk("rst_diff", {56'd0, d8}, 64'd0);
        chk("rst_flags", {62'd0, bo8, of8}, 64'd0);
        #9;
        rst8  = 1'b0;
        rst32 = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].of, 1'b1);
        end

        // Backpressure, then retire with a simultaneous in_valid.
        run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {63'd0, ov8}, 64'd1);
            chk("bp_diff", {56'd0, d8}, 64'hFE);
            chk("bp_flags", {62'd0, bo8, of8}, 64'd2);
            chk("bp_in_ready", {63'd0, ir8}, 64'd0);
        end
        or8 = 1'b1; iv8 = 1'b1; a8 = 8'h44; b8 = 8'h04;
        @(posedge clk); #1;
        or8 = 1'b0; iv8 = 1'b0;
        chk("retire_no_accept_in_ready", {63'd0, ir8}, 64'd1);
        chk("retire_out_valid", {63'd0, ov8}, 64'd0);
        chk("idle_result_visible", {56'd0, d8}, 64'hFE);
        run8(8'h44, 8'h04, 8'h40, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset three edges into RUN.
        a8 = 8'h33; b8 = 8'h11; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst8 = 1'b1;
        #1;
        chk("midrun_rst_in_ready", {63'd0, ir8}, 64'd1);
        chk("midrun_rst_out_valid", {63'd0, ov8}, 64'd0);
        chk("midrun_rst_diff", {56'd0, d8}, 64'd0);
        chk("midrun_rst_flags", {62'd0, bo8, of8}, 64'd0);
        @(negedge clk);
        rst8 = 1'b0;
        run8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1);

        // 32-bit random traffic against a scoreboard.
        fork
            begin : drv
                logic [31:0] ra, rb, rd;
                exp_t e;
                int k;
                for (int n = 0; n < N_RAND; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                        a32 = $urandom; b32 = $urandom;
                    end
                    ra = $urandom; rb = $urandom;
                    case ($urandom_range(0, 7))
                        0: rb = ra;
                        1: begin ra = 32'd0; rb = 32'd1; end
                        default: ;
                    endcase
                    a32 = ra; b32 = rb; iv32 = 1'b1;
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (!ir32 && k < 200);
                    if (!ir32) begin
                        failures++;
                        $display("FAIL rand_accept_timeout actual=in_ready_low required=in_ready_high");
                        break;
                    end
                    rd   = ra - rb;
                    e.d  = rd;
                    e.bo = (ra < rb);
                    e.of = (ra[31] != rb[31]) && (rd[31] != ra[31]);
                    sb_q.push_back(e);
                    @(posedge clk); #1;
                    iv32 = 1'b0;
                    a32 = $urandom; b32 = $urandom;
                end
                iv32 = 1'b0;
            end
            begin : mon
                exp_t e;
                int rx;
                int cyc;
                rx = 0; cyc = 0;
                while (rx < N_RAND && cyc < N_RAND * 80) begin
                    @(negedge clk);
                    cyc++;
                    or32 = ($urandom_range(0, 3) != 0);
                    if (ov32 && or32) begin
                        if (sb_q.size() == 0) begin
                            failures++;
                            $display("FAIL rand_unexpected_result actual=0x%0h required=none", d32);
                        end else begin
                            e = sb_q.pop_front();
                            chk("rand_diff", {32'd0, d32}, {32'd0, e.d});
                            chk("rand_flags", {62'd0, bo32, of32}, {62'd0, e.bo, e.of});
                        end
                        rx++;
                    end
                end
                if (rx < N_RAND) begin
                    failures++;
                    $display("FAIL rand_results_timeout actual=%0d required=%0d", rx, N_RAND);
                end
                or32 = 1'b0;
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
